// File: rtl/e_muldiv_unit.sv
// e_muldiv_unit: E-stage HI/LO multiply/divide unit; multi-cycle latency modelled by a busy counter.
// Define MULT_ACC_EN to enable MADD/MADDU (ops 9/10); otherwise those codes act as NONE.
module e_muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        start,
    output logic        busy,
    output logic [31:0] MDdata_E,
    output logic [31:0] HI_o,
    output logic [31:0] LO_o
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    logic [31:0] hi, lo, pend_hi, pend_lo;
    logic [CW-1:0] cnt;
    logic is_mul, is_div, is_acc, ovf;
    logic [63:0] prod_s, prod_u, res;
    logic [31:0] sdiv_b, udiv_b, sq, sr, uq, ur;
    assign is_mul = md_op == 4'd1 || md_op == 4'd2;
    assign is_div = md_op == 4'd3 || md_op == 4'd4;
`ifdef MULT_ACC_EN
    assign is_acc = md_op == 4'd9 || md_op == 4'd10;
`else
    assign is_acc = 1'b0;
`endif
    assign start = (is_mul || is_div || is_acc) && !busy && !Req;
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};
    // Divisors are forced to 1 for the cases resolved by muxing, so the divider never sees /0 or INT_MIN/-1
    assign ovf = A == 32'h8000_0000 && B == 32'hFFFF_FFFF;
    assign sdiv_b = (B == 32'd0 || ovf) ? 32'd1 : B;
    assign udiv_b = (B == 32'd0) ? 32'd1 : B;
    assign sq = $signed(A) / $signed(sdiv_b);
    assign sr = $signed(A) % $signed(sdiv_b);
    assign uq = A / udiv_b;
    assign ur = A % udiv_b;
    always_comb begin
        res = md_op == 4'd1 ? prod_s :
              md_op == 4'd2 ? prod_u :
              (is_div && B == 32'd0) ? {A, 32'hFFFF_FFFF} :
              md_op == 4'd3 ? (ovf ? {32'd0, 32'h8000_0000} : {sr, sq}) :
              md_op == 4'd4 ? {ur, uq} :
              md_op == 4'd9 ? {hi, lo} + prod_s : {hi, lo} + prod_u;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            cnt <= '0;
            busy <= 1'b0;
        end else if (busy) begin
            if (cnt == CW'(1)) begin
                hi <= pend_hi;
                lo <= pend_lo;
                busy <= 1'b0;
            end
            cnt <= cnt - CW'(1);
        end else if (!Req) begin
            if (start) begin
                {pend_hi, pend_lo} <= res;
                cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                busy <= 1'b1;
            end else if (md_op == 4'd7) begin
                hi <= A;
            end else if (md_op == 4'd8) begin
                lo <= A;
            end
        end
    end
    assign MDdata_E = md_op == 4'd5 ? hi : md_op == 4'd6 ? lo : 32'd0;
    assign HI_o = hi;
    assign LO_o = lo;
endmodule

// File: tb/tb_e_muldiv_unit.sv
// tb_e_muldiv_unit: random and directed stimulus against an arithmetic reference model of HI/LO and busy timing.
module tb_e_muldiv_unit;
    localparam int MC = 5;
    localparam int DC = 10;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] md_op = 4'd0;
    logic [31:0] A = 32'd0, B = 32'd0;
    logic Req = 1'b0;
    logic start, busy;
    logic [31:0] MDdata_E, HI_o, LO_o;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int m_rem = 0;

    e_muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .A(A), .B(B), .Req(Req),
        .start(start), .busy(busy), .MDdata_E(MDdata_E), .HI_o(HI_o), .LO_o(LO_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit launches(input logic [3:0] op);
`ifdef MULT_ACC_EN
        return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10};
`else
        return op inside {4'd1, 4'd2, 4'd3, 4'd4};
`endif
    endfunction

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] hi, input logic [31:0] lo);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        logic [31:0] q, r;
        case (op)
            4'd1: return sa * sb;
            4'd2: return ua * ub;
            4'd3, 4'd4: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = (op == 4'd3) ? 32'(sa / sb) : 32'(ua / ub);
                r = (op == 4'd3) ? 32'(sa % sb) : 32'(ua % ub);
                return {r, q};
            end
            4'd9: return {hi, lo} + 64'(sa * sb);
            default: return {hi, lo} + ua * ub;
        endcase
    endfunction

    // Drive one cycle, compare every output against the model, then advance the model across the edge
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic req, input logic rst);
        @(negedge clk);
        md_op = op; A = a; B = b; Req = req; reset = rst;
        #1;
        check("start", {31'd0, start}, {31'd0, launches(op) && m_rem == 0 && !req});
        check("busy", {31'd0, busy}, {31'd0, m_rem != 0});
        check("mddata", MDdata_E, op == 4'd5 ? m_hi : op == 4'd6 ? m_lo : 32'd0);
        check("hi", HI_o, m_hi);
        check("lo", LO_o, m_lo);
        @(posedge clk);
        if (rst) begin
            m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (!req) begin
            if (launches(op)) begin
                {p_hi, p_lo} = ref_result(op, a, b, m_hi, m_lo);
                m_rem = (op == 4'd3 || op == 4'd4) ? DC : MC;
            end else if (op == 4'd7) m_hi = a;
            else if (op == 4'd8) m_lo = a;
        end
    endtask

    task automatic idle();
        step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        step(op, a, b, 1'b0, 1'b0);
        for (int i = 0; i < 20 && m_rem > 0; i++) idle();
        idle();
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 9);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        step(4'd0, 0, 0, 1'b0, 1'b1);
        step(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(); idle();
        step(4'd0, 0, 0, 1'b0, 1'b1);
        step(4'd5, 0, 0, 1'b0, 1'b0);
        check("rst_mid_div_hi", HI_o, 32'd0);

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi", HI_o, 32'hFFFF_FFFF);
        check("mult_lo", LO_o, 32'hFFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3);
        check("multu_hi", HI_o, 32'h0000_0002);
        check("multu_lo", LO_o, 32'hFFFF_FFFA);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", LO_o, 32'hFFFF_FFFD);
        check("div_hi", HI_o, 32'hFFFF_FFFF);
        run_op(4'd4, 32'd7, 32'd0);
        check("divu0_lo", LO_o, 32'hFFFF_FFFF);
        check("divu0_hi", HI_o, 32'd7);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf_lo", LO_o, 32'h8000_0000);
        check("divovf_hi", HI_o, 32'd0);

        step(4'd1, 32'd5, 32'd6, 1'b1, 1'b0);
        idle();
        step(4'd1, 32'd5, 32'd6, 1'b0, 1'b0);
        step(4'd0, 0, 0, 1'b1, 1'b0);
        step(4'd8, 32'd99, 0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) idle();
        check("req_inflight_lo", LO_o, 32'd30);
        step(4'd8, 32'hDEAD_BEEF, 0, 1'b1, 1'b0);
        idle();
        check("mtlo_req_lo", LO_o, 32'd30);
        step(4'd7, 32'h1234_5678, 0, 1'b0, 1'b0);
        step(4'd5, 0, 0, 1'b0, 1'b0);
        check("mthi_mfhi", HI_o, 32'h1234_5678);

        step(4'd1, 32'd4, 32'd4, 1'b0, 1'b0);
        step(4'd3, 32'd100, 32'd3, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) idle();
        check("div_while_busy_lo", LO_o, 32'd16);

        step(4'd7, 32'd0, 0, 1'b0, 1'b0);
        step(4'd8, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        run_op(4'd10, 32'd1, 32'd1);
`ifdef MULT_ACC_EN
        check("maddu_hi", HI_o, 32'd1);
        check("maddu_lo", LO_o, 32'd0);
`else
        check("maddu_off_hi", HI_o, 32'd0);
        check("maddu_off_lo", LO_o, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 3000; i++) begin
            step(4'($urandom_range(0, 15)), pick(), pick(), $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
